// File: rtl/aclk_load_sequencer.sv
// Arbitrates user-panel/time-sync load requests into the alarm clock core; ready at c0, LD at c2..1+HOLD_CYCLES, done at 2+HOLD_CYCLES (alarm) or up to 2+HOLD_CYCLES+VERIFY_TIMEOUT (time).
// Backpressure: a requester holds valid until its ready pulse; requests arriving while busy wait in IDLE arbitration.
module aclk_load_sequencer #(
    parameter int HOLD_CYCLES    = 1,
    parameter int VERIFY_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       r0_valid,
    input  logic       r0_is_alarm,
    input  logic [13:0] r0_data,
    output logic       r0_ready,
    output logic       r0_done,
    input  logic       r1_valid,
    input  logic       r1_is_alarm,
    input  logic [13:0] r1_data,
    output logic       r1_ready,
    output logic       r1_done,
    output logic       resp_err,
    output logic [1:0] resp_code,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    input  logic [1:0] H_out1,
    input  logic [3:0] H_out0,
    input  logic [3:0] M_out1,
    input  logic [3:0] M_out0,
    output logic       busy
);
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOAD, S_VERIFY, S_RESP} state_t;

    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] VERIFY_LAST = 4'(VERIFY_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_q, gnt_d;
    logic        r0_ready_q, r0_ready_d, r1_ready_q, r1_ready_d;
    logic        r0_done_q, r0_done_d, r1_done_q, r1_done_d;
    logic        is_alarm_q, is_alarm_d;
    logic [13:0] data_q, data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        resp_err_q, resp_err_d;
    logic [1:0]  resp_code_q, resp_code_d;
    logic [13:0] bus_q, bus_d;
    logic        ld_time_q, ld_time_d, ld_alarm_q, ld_alarm_d;
    logic        busy_q, busy_d;

    logic        want_grant, pick, data_legal;
    logic [13:0] readback;

    assign readback = {H_out1, H_out0, M_out1, M_out0};

    always_comb begin
        data_legal = (data_q[13:12] <= 2'd2) && (data_q[11:8] <= 4'd9) &&
                     !((data_q[13:12] == 2'd2) && (data_q[11:8] > 4'd3)) &&
                     (data_q[7:4] <= 4'd5) && (data_q[3:0] <= 4'd9);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        r0_ready_d   = 1'b0;
        r1_ready_d   = 1'b0;
        is_alarm_d   = is_alarm_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        resp_err_d   = resp_err_q;
        resp_code_d  = resp_code_q;

        // Grant is decided one cycle ahead (IDLE without a pending accept, or RESP)
        // so the ready pulse can land in the first IDLE cycle after a response.
        want_grant = ((state_q == S_IDLE) && !(r0_ready_q || r1_ready_q)) || (state_q == S_RESP);
        pick       = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;

        case (state_q)
            S_IDLE: begin
                if (r0_ready_q || r1_ready_q) begin
                    is_alarm_d = gnt_q ? r1_is_alarm : r0_is_alarm;
                    data_d     = gnt_q ? r1_data : r0_data;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_d = 4'd0;
                if (data_legal) begin
                    state_d = S_LOAD;
                end else begin
                    resp_code_d = 2'b01;
                    resp_err_d  = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_LOAD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = 4'd0;
                    if (is_alarm_q) begin
                        resp_code_d = 2'b00;
                        resp_err_d  = 1'b0;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_VERIFY;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_VERIFY: begin
                if (readback == data_q) begin
                    resp_code_d = 2'b00;
                    resp_err_d  = 1'b0;
                    state_d     = S_RESP;
                end else if (cnt_q == VERIFY_LAST) begin
                    resp_code_d = 2'b10;
                    resp_err_d  = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (want_grant && (r0_valid || r1_valid)) begin
            gnt_d        = pick;
            last_grant_d = pick;
            r0_ready_d   = ~pick;
            r1_ready_d   = pick;
        end

        r0_done_d  = (state_d == S_RESP) && !gnt_q;
        r1_done_d  = (state_d == S_RESP) && gnt_q;
        busy_d     = (state_d != S_IDLE);
        ld_time_d  = (state_d == S_LOAD) && !is_alarm_d;
        ld_alarm_d = (state_d == S_LOAD) && is_alarm_d;
        bus_d      = ((state_d == S_LOAD) || (state_d == S_VERIFY)) ? data_d : 14'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            r0_ready_q   <= 1'b0;
            r1_ready_q   <= 1'b0;
            r0_done_q    <= 1'b0;
            r1_done_q    <= 1'b0;
            is_alarm_q   <= 1'b0;
            data_q       <= 14'd0;
            cnt_q        <= 4'd0;
            resp_err_q   <= 1'b0;
            resp_code_q  <= 2'b00;
            bus_q        <= 14'd0;
            ld_time_q    <= 1'b0;
            ld_alarm_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            r0_ready_q   <= r0_ready_d;
            r1_ready_q   <= r1_ready_d;
            r0_done_q    <= r0_done_d;
            r1_done_q    <= r1_done_d;
            is_alarm_q   <= is_alarm_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            resp_err_q   <= resp_err_d;
            resp_code_q  <= resp_code_d;
            bus_q        <= bus_d;
            ld_time_q    <= ld_time_d;
            ld_alarm_q   <= ld_alarm_d;
            busy_q       <= busy_d;
        end
    end

    assign r0_ready  = r0_ready_q;
    assign r1_ready  = r1_ready_q;
    assign r0_done   = r0_done_q;
    assign r1_done   = r1_done_q;
    assign resp_err  = resp_err_q;
    assign resp_code = resp_code_q;
    assign {H_in1, H_in0, M_in1, M_in0} = bus_q;
    assign LD_time   = ld_time_q;
    assign LD_alarm  = ld_alarm_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_aclk_load_sequencer.sv
// Directed bench for aclk_load_sequencer with a small echoing core model; cycle 0 is the ready pulse.
module tb_aclk_load_sequencer;
    localparam int HOLD = 1;
    localparam int VT   = 4;

    logic clk = 1'b0;
    logic reset;
    logic r0_valid, r0_is_alarm, r1_valid, r1_is_alarm;
    logic [13:0] r0_data, r1_data;
    logic r0_ready, r0_done, r1_ready, r1_done, resp_err;
    logic [1:0] resp_code;
    logic [1:0] H_in1, H_out1;
    logic [3:0] H_in0, M_in1, M_in0, H_out0, M_out1, M_out0;
    logic LD_time, LD_alarm, busy;

    logic [13:0] core_time;
    logic        stuck;

    int vectors = 0;
    int miscompares = 0;

    logic       rec_ldt [0:15];
    logic       rec_lda [0:15];
    logic       rec_d0  [0:15];
    logic       rec_d1  [0:15];
    logic       rec_err [0:15];
    logic [1:0] rec_code[0:15];
    logic       rec_busy[0:15];

    always #5 clk = ~clk;

    aclk_load_sequencer #(.HOLD_CYCLES(HOLD), .VERIFY_TIMEOUT(VT)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_is_alarm(r0_is_alarm), .r0_data(r0_data),
        .r0_ready(r0_ready), .r0_done(r0_done),
        .r1_valid(r1_valid), .r1_is_alarm(r1_is_alarm), .r1_data(r1_data),
        .r1_ready(r1_ready), .r1_done(r1_done),
        .resp_err(resp_err), .resp_code(resp_code),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .busy(busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        core_time <= 14'd0;
        else if (LD_time) core_time <= {H_in1, H_in0, M_in1, M_in0};
    end
    assign {H_out1, H_out0, M_out1, M_out0} = stuck ? 14'd0 : core_time;

    task automatic do_reset();
        reset = 1'b1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ready(output int who, output bit ok, output bit saw_done);
        ok = 1'b0;
        who = -1;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (r0_done || r1_done) saw_done = 1'b1;
            if (r0_ready || r1_ready) begin
                who = r1_ready ? 1 : 0;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic record(input int n);
        for (int k = 0; k <= n; k++) begin
            if (k > 0) @(negedge clk);
            rec_ldt[k]  = LD_time;
            rec_lda[k]  = LD_alarm;
            rec_d0[k]   = r0_done;
            rec_d1[k]   = r1_done;
            rec_err[k]  = resp_err;
            rec_code[k] = resp_code;
            rec_busy[k] = busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_is_alarm = 1'b0; r1_is_alarm = 1'b0;
        r0_data = 14'd0; r1_data = 14'd0;
        stuck = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({r0_ready, r1_ready, r0_done, r1_done, LD_time, LD_alarm, busy, resp_err} !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {r0_ready, r1_ready, r0_done, r1_done, LD_time, LD_alarm, busy, resp_err});
        end
        vectors++;
        if ({H_in1, H_in0, M_in1, M_in0, resp_code} !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_bus: got %h want 0000", {H_in1, H_in0, M_in1, M_in0, resp_code});
        end
        reset = 1'b0;
    endtask

    task automatic test_time_load();
        int who; bit ok, sd;
        do_reset();
        r0_is_alarm = 1'b0;
        r0_data = {2'b01, 4'b0010, 4'b0011, 4'b0100};
        r0_valid = 1'b1;
        wait_ready(who, ok, sd);
        r0_valid = 1'b0;
        vectors++;
        if (!ok || who != 0) begin
            miscompares++;
            $display("FAIL time_ready: got who=%0d ok=%0d want who=0 ok=1", who, ok);
        end
        record(6);
        for (int k = 0; k <= 6; k++) begin
            vectors++;
            if ({rec_ldt[k], rec_lda[k], rec_d0[k], rec_d1[k]} !== {k == 2, 1'b0, k == 4, 1'b0}) begin
                miscompares++;
                $display("FAIL time_trace c%0d: got ldt/lda/d0/d1=%b want %b", k,
                         {rec_ldt[k], rec_lda[k], rec_d0[k], rec_d1[k]}, {k == 2, 1'b0, k == 4, 1'b0});
            end
        end
        vectors++;
        if ({rec_err[4], rec_code[4]} !== 3'b000) begin
            miscompares++;
            $display("FAIL time_resp: got err/code=%b want 000", {rec_err[4], rec_code[4]});
        end
    endtask

    task automatic test_alarm_load();
        int who; bit ok, sd;
        r1_is_alarm = 1'b1;
        r1_data = {2'b10, 4'b0011, 4'b0101, 4'b1001};
        r1_valid = 1'b1;
        wait_ready(who, ok, sd);
        r1_valid = 1'b0;
        vectors++;
        if (!ok || who != 1) begin
            miscompares++;
            $display("FAIL alarm_ready: got who=%0d ok=%0d want who=1 ok=1", who, ok);
        end
        record(5);
        for (int k = 0; k <= 5; k++) begin
            vectors++;
            if ({rec_ldt[k], rec_lda[k], rec_d0[k], rec_d1[k], rec_busy[k]} !==
                {1'b0, k == 2, 1'b0, k == 3, (k >= 1 && k <= 3)}) begin
                miscompares++;
                $display("FAIL alarm_trace c%0d: got ldt/lda/d0/d1/busy=%b want %b", k,
                         {rec_ldt[k], rec_lda[k], rec_d0[k], rec_d1[k], rec_busy[k]},
                         {1'b0, k == 2, 1'b0, k == 3, (k >= 1 && k <= 3)});
            end
        end
        vectors++;
        if ({rec_err[3], rec_code[3]} !== 3'b000) begin
            miscompares++;
            $display("FAIL alarm_resp: got err/code=%b want 000", {rec_err[3], rec_code[3]});
        end
    endtask

    task automatic test_range_error();
        int who; bit ok, sd;
        logic [13:0] bad [0:1];
        bad[0] = {2'b10, 4'b0100, 4'b0000, 4'b0000};
        bad[1] = {2'b00, 4'b0111, 4'b0110, 4'b0000};
        for (int t = 0; t < 2; t++) begin
            r0_is_alarm = 1'b0;
            r0_data = bad[t];
            r0_valid = 1'b1;
            wait_ready(who, ok, sd);
            r0_valid = 1'b0;
            vectors++;
            if (!ok || who != 0) begin
                miscompares++;
                $display("FAIL range_ready%0d: got who=%0d ok=%0d want who=0 ok=1", t, who, ok);
            end
            record(4);
            for (int k = 0; k <= 4; k++) begin
                vectors++;
                if ({rec_ldt[k], rec_lda[k], rec_d0[k], rec_d1[k]} !== {2'b00, k == 2, 1'b0}) begin
                    miscompares++;
                    $display("FAIL range_trace%0d c%0d: got ldt/lda/d0/d1=%b want %b", t, k,
                             {rec_ldt[k], rec_lda[k], rec_d0[k], rec_d1[k]}, {2'b00, k == 2, 1'b0});
                end
            end
            vectors++;
            if ({rec_err[2], rec_code[2]} !== 3'b101) begin
                miscompares++;
                $display("FAIL range_resp%0d: got err/code=%b want 101", t, {rec_err[2], rec_code[2]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic rd0 [0:39];
        logic rd1 [0:39];
        logic dn0 [0:39];
        logic dn1 [0:39];
        logic bsy [0:39];
        int grants [$];
        int dones  [$];
        int done_at[$];
        int nready;
        do_reset();
        r0_is_alarm = 1'b1; r0_data = {2'b00, 4'b0110, 4'b0011, 4'b0000};
        r1_is_alarm = 1'b1; r1_data = {2'b01, 4'b1000, 4'b0100, 4'b0101};
        r0_valid = 1'b1; r1_valid = 1'b1;
        nready = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rd0[c] = r0_ready; rd1[c] = r1_ready;
            dn0[c] = r0_done;  dn1[c] = r1_done;
            bsy[c] = busy;
            if (r0_ready || r1_ready) nready++;
            if (nready == 4) begin
                r0_valid = 1'b0;
                r1_valid = 1'b0;
            end
        end
        for (int c = 0; c < 40; c++) begin
            if (rd0[c] || rd1[c]) grants.push_back(rd1[c] ? 1 : 0);
            if (dn0[c] || dn1[c]) begin
                dones.push_back(dn1[c] ? 1 : 0);
                done_at.push_back(c);
            end
            vectors++;
            if ((dn0[c] && dn1[c]) || (rd0[c] && rd1[c])) begin
                miscompares++;
                $display("FAIL b2b_exclusive c%0d: got rd=%b%b dn=%b%b want at most one", c,
                         rd0[c], rd1[c], dn0[c], dn1[c]);
            end
        end
        vectors++;
        if (grants.size() != 4 || dones.size() != 4) begin
            miscompares++;
            $display("FAIL b2b_count: got grants=%0d dones=%0d want 4/4", grants.size(), dones.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (grants[i] != (i % 2) || dones[i] != (i % 2)) begin
                    miscompares++;
                    $display("FAIL b2b_order%0d: got grant=%0d done=%0d want %0d", i,
                             grants[i], dones[i], i % 2);
                end
            end
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (done_at[i] + 2 >= 40 || bsy[done_at[i] + 1] !== 1'b0 || bsy[done_at[i] + 2] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_gap%0d: got busy gap not exactly one cycle after done at c%0d", i, done_at[i]);
                end
            end
        end
    endtask

    task automatic test_verify_timeout();
        int who; bit ok, sd;
        do_reset();
        stuck = 1'b1;
        r0_is_alarm = 1'b0;
        r0_data = {2'b00, 4'b0101, 4'b0000, 4'b0101};
        r0_valid = 1'b1;
        wait_ready(who, ok, sd);
        r0_valid = 1'b0;
        vectors++;
        if (!ok || who != 0) begin
            miscompares++;
            $display("FAIL tmo_ready: got who=%0d ok=%0d want who=0 ok=1", who, ok);
        end
        record(9);
        for (int k = 0; k <= 9; k++) begin
            vectors++;
            if ({rec_ldt[k], rec_d0[k], rec_busy[k]} !== {k == 2, k == 7, (k >= 1 && k <= 7)}) begin
                miscompares++;
                $display("FAIL tmo_trace c%0d: got ldt/d0/busy=%b want %b", k,
                         {rec_ldt[k], rec_d0[k], rec_busy[k]}, {k == 2, k == 7, (k >= 1 && k <= 7)});
            end
        end
        vectors++;
        if ({rec_err[7], rec_code[7]} !== 3'b110) begin
            miscompares++;
            $display("FAIL tmo_resp: got err/code=%b want 110", {rec_err[7], rec_code[7]});
        end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int who; bit ok, sd;
        do_reset();
        r0_is_alarm = 1'b0;
        r0_data = {2'b00, 4'b1001, 4'b0001, 4'b0101};
        r1_is_alarm = 1'b1;
        r1_data = {2'b00, 4'b0110, 4'b0000, 4'b0000};
        r0_valid = 1'b1;
        wait_ready(who, ok, sd);
        r0_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (LD_time !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_ld: got LD_time=%b want 1", LD_time);
        end
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({LD_time, LD_alarm, busy, r0_done, H_in1, H_in0, M_in1, M_in0} !== 18'd0) begin
            miscompares++;
            $display("FAIL rst_async: got %h want 00000",
                     {LD_time, LD_alarm, busy, r0_done, H_in1, H_in0, M_in1, M_in0});
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_ready(who, ok, sd);
        r0_valid = 1'b0;
        vectors++;
        if (!ok || who != 0 || sd) begin
            miscompares++;
            $display("FAIL rst_regrant_both: got who=%0d ok=%0d done_seen=%0d want who=0 ok=1 done_seen=0",
                     who, ok, sd);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_ready(who, ok, sd);
        r1_valid = 1'b0;
        vectors++;
        if (!ok || who != 1 || sd) begin
            miscompares++;
            $display("FAIL rst_regrant_r1: got who=%0d ok=%0d done_seen=%0d want who=1 ok=1 done_seen=0",
                     who, ok, sd);
        end
        record(4);
        vectors++;
        if ({rec_lda[2], rec_d1[3], rec_d0[3]} !== 3'b110) begin
            miscompares++;
            $display("FAIL rst_r1_complete: got lda2/d1_3/d0_3=%b want 110",
                     {rec_lda[2], rec_d1[3], rec_d0[3]});
        end
    endtask

    initial begin
        test_reset();
        test_time_load();
        test_alarm_load();
        test_range_error();
        test_back_to_back();
        test_verify_timeout();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/aclk_load_sequencer.md
Name: aclk_load_sequencer

Overview:
- Sequences all clock/alarm load operations into the alarm clock core. Sole driver of the core's H_in1/H_in0/M_in1/M_in0/LD_time/LD_alarm bus.
- Two requesters share the core:
  - requester 0 is the user panel;
  - requester 1 is the time-sync source.
- For each request the block arbitrates, range-checks the BCD value, pulses the correct load strobe, and reads back the core outputs to confirm time loads.
- It then returns a done/error response to the requester.

Parameters:
- HOLD_CYCLES, 1, number of cycles LD_time/LD_alarm stays asserted (1..7).
- VERIFY_TIMEOUT, 4, maximum cycles in VERIFY waiting for core readback to match (1..15).

Ports:
- clk  input  1  sequencer clock; same clock as the alarm clock core.
- reset  input  1  asynchronous, active-high reset.
- r0_valid  input  1  requester 0 request pending; held until r0_ready.
- r0_is_alarm  input  1  1 = load alarm, 0 = load time.
- r0_data  input  14  {H1[1:0], H0[3:0], M1[3:0], M0[3:0]} BCD.
- r0_ready  output  1  one-cycle accept pulse; data captured this cycle.
- r0_done  output  1  one-cycle completion pulse.
- r1_valid, r1_is_alarm, r1_data, r1_ready, r1_done: same as requester 0, for requester 1.
- resp_err  output  1  valid with rN_done; 1 = request failed.
- resp_code  output  2  valid with rN_done: 00 ok, 01 range error, 10 verify timeout.
- H_in1  output  2  to core.
- H_in0  output  4  to core.
- M_in1  output  4  to core.
- M_in0  output  4  to core.
- LD_time  output  1  to core.
- LD_alarm  output  1  to core.
- H_out1  input  2  core readback.
- H_out0  input  4  core readback.
- M_out1  input  4  core readback.
- M_out0  input  4  core readback.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs are registered and reset to 0. The FSM resets to IDLE. last_grant resets to 1, so requester 0 wins the first tie.
- FSM states: IDLE, CHECK, LOAD, VERIFY, RESP.
- IDLE:
  - Only requester 0 valid: grant 0. Only requester 1 valid: grant 1.
  - Both valid: round-robin; grant the requester that was not last_grant.
  - On grant, pulse rN_ready for one cycle, capture is_alarm and data, update last_grant, go to CHECK.
  - No valid: stay in IDLE.
  - A valid that drops before ready is ignored. The requester must not change data while valid is high.
- CHECK (1 cycle):
  - Legal values: H1<=2; H0<=9; H1==2 requires H0<=3; M1<=5; M0<=9.
  - Illegal: resp_code=01, go to RESP; no strobe is issued.
  - Legal: go to LOAD.
- LOAD (HOLD_CYCLES cycles):
  - Drive the captured value on H_in*/M_in*.
  - Assert LD_alarm if is_alarm, else LD_time. The two strobes are never both high.
  - At the end, alarm loads go to RESP with resp_code=00; time loads go to VERIFY.
- VERIFY (at most VERIFY_TIMEOUT cycles):
  - LD_* are low. Keep driving the captured value on H_in*/M_in*.
  - Each cycle, compare {H_out1,H_out0,M_out1,M_out0} with the captured value.
  - Match: resp_code=00, go to RESP.
  - VERIFY_TIMEOUT cycles without a match: resp_code=10, go to RESP.
- RESP (1 cycle):
  - Pulse rN_done for the granted requester only.
  - resp_err = (resp_code != 00). resp_code is held stable while done is high.
  - Go to IDLE. A new grant is possible in the first IDLE cycle after RESP.
- Data bus: H_in*/M_in* drive 0 in IDLE, CHECK and RESP; they carry the captured value only in LOAD and VERIFY.
- Latency, with the ready pulse at cycle 0:
  - CHECK at 1; LD high over cycles 2..1+HOLD_CYCLES.
  - Alarm load: done at 2+HOLD_CYCLES.
  - Range error: done at 2.
  - Time load, match on the first VERIFY cycle: done at 3+HOLD_CYCLES.
- A request arriving while busy waits; its valid stays high until its ready pulse.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No done pulse is issued for the aborted request; the requester must reissue it. last_grant returns to 1.

Test Plan:
- Reset, then r0 time load 12:34 (r0_data={01,0010,0011,0100}), core model echoing the load, HOLD_CYCLES=1 -> r0_ready at cycle 0; LD_time high only at cycle 2; r0_done with resp_code=00 at cycle 4.
- r1 alarm load 23:59 -> LD_alarm one cycle at cycle 2, LD_time stays 0; r1_done with resp_code=00 at cycle 3; no VERIFY state.
- r0 time load 24:00, then separately 07:60 -> no LD strobe; r0_done with resp_err=1, resp_code=01 at cycle 2 for each.
- Both valid every cycle, 4 back-to-back alarm loads -> grants in order 0,1,0,1; each done pulse goes only to the matching requester; busy low for exactly one cycle between jobs.
- Time load 05:05, core readback stuck at 00:00, VERIFY_TIMEOUT=4 -> after 4 VERIFY cycles, r0_done with resp_code=10, resp_err=1.
- Reset asserted during LOAD -> LD_* drop to 0 asynchronously, no done pulse; after release, a pending r1 request is granted before r0 only if r0_valid is low.
